// File: rtl/data_mem_pkg.sv
// Shared types and constants for the CPU data-memory controller.
// Holds the FSM state encoding, default widths/SP mapping and the byte-lane merge helper.
// The merge helper works on a wide container so any DATA_W up to MERGE_W can use it.
package data_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [15:0] SP_ADDR = 16'hFFFE;
  localparam logic [15:0] SP_INIT = 16'h03FF;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W  = 128;
  localparam int MERGE_NB = MERGE_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Replace the byte lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_w,
    input logic [MERGE_W-1:0]  new_w,
    input logic [MERGE_NB-1:0] be
  );
    logic [MERGE_W-1:0] m;
    m = old_w;
    for (int i = 0; i < MERGE_NB; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// Synchronous single-port word RAM with per-lane write enables.
// Latency: write lands at the clock edge; read data is registered one edge after i_rd.
// No backpressure and no reset; the read register holds its value until the next i_rd.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_rd,
  input  logic [NB-1:0]     i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Lane-wise write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    if (i_rd) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: word array plus a memory-mapped stack-pointer register.
// Latency: response sampled WAIT_STATES+1 edges after the accept edge; one request per WAIT_STATES+2 cycles.
// Backpressure: req_ready is high only in IDLE; requests presented while busy are ignored.
module data_mem_ctrl #(
  parameter int                    DATA_W      = data_mem_pkg::DATA_W,
  parameter int                    ADDR_W      = data_mem_pkg::ADDR_W,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_W-1:0]     SP_ADDR     = data_mem_pkg::SP_ADDR,
  parameter logic [DATA_W-1:0]     SP_INIT     = data_mem_pkg::SP_INIT,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   sp_value
);

  import data_mem_pkg::*;

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  // DEPTH widened by one bit so the range compare never truncates the address.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WS_LAST = 4'(WAIT_STATES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] r_sp_rd;
  logic              r_write;
  logic              r_is_sp;
  logic              r_err;

  logic              w_accept;
  logic              w_is_sp;
  logic              w_in_rng;
  logic              w_err;
  logic              w_mem_rd;
  logic [NB-1:0]     w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_sp_merged;

  assign w_accept    = req_valid && req_ready;
  assign w_is_sp     = (req_addr == SP_ADDR);
  assign w_in_rng    = ({1'b0, req_addr} < DEPTH_X);
  assign w_err       = !w_is_sp && !w_in_rng;
  // The SP register shadows the array, so an SP access never touches the RAM.
  assign w_mem_rd    = w_accept && !req_write && w_in_rng && !w_is_sp;
  assign w_mem_we    = (w_accept && req_write && w_in_rng && !w_is_sp) ? req_be : '0;
  assign w_sp_merged = DATA_W'(be_merge(MERGE_W'(r_sp), MERGE_W'(req_wdata), MERGE_NB'(req_be)));

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_rd    (w_mem_rd),
    .i_we    (w_mem_we),
    .i_addr  (req_addr[AW-1:0]),
    .i_wdata (req_wdata),
    .o_rdata (w_mem_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (r_wait_cnt == WS_LAST) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wait-state counter: runs 0..WAIT_STATES-1 while in WAIT, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_wait_cnt <= '0;
    else if (r_state != WAIT)   r_wait_cnt <= '0;
    else if (r_wait_cnt == WS_LAST) r_wait_cnt <= '0;
    else                        r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  // Stack-pointer register, written lane-wise at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_sp <= SP_INIT;
    else if (w_accept && req_write && w_is_sp) r_sp <= w_sp_merged;
  end

  // Request attributes held until the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_is_sp <= 1'b0;
      r_err   <= 1'b0;
      r_sp_rd <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_is_sp <= w_is_sp;
      r_err   <= w_err;
      if (!req_write && w_is_sp) r_sp_rd <= r_sp;
    end
  end

  // Response mux: data only for successful reads, zero otherwise.
  assign rsp_rdata = (rsp_valid && !r_write && !r_err) ? (r_is_sp ? r_sp_rd : w_mem_rdata) : '0;
  assign rsp_err   = rsp_valid && r_err;
  assign sp_value  = r_sp;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) against a word-level model.
// Directed scenarios then random traffic; each request's latency, busy window and response are checked.
// Expected values come from an array/SP model updated per accepted request.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        vld  [2];
  logic        wr   [2];
  logic [15:0] addr [2];
  logic [15:0] wdat [2];
  logic [1:0]  be   [2];
  logic        rdy  [2];
  logic        rv   [2];
  logic        rerr [2];
  logic [15:0] rdat [2];
  logic [15:0] spv  [2];

  logic [15:0] mm   [2][1024];
  bit          kn   [2][1024];
  logic [15:0] sp_m [2];
  logic [15:0] e_rd;
  bit          e_known;
  bit          e_err;

  int tests = 0;
  int fails = 0;
  int nw;

  data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .req_addr(addr[0]), .req_wdata(wdat[0]), .req_be(be[0]), .rsp_valid(rv[0]),
    .rsp_rdata(rdat[0]), .rsp_err(rerr[0]), .sp_value(spv[0])
  );

  data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .req_addr(addr[1]), .req_wdata(wdat[1]), .req_be(be[1]), .rsp_valid(rv[1]),
    .rsp_rdata(rdat[1]), .rsp_err(rerr[1]), .sp_value(spv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] b);
    logic [15:0] r;
    r = o;
    if (b[0]) r[7:0]  = n[7:0];
    if (b[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  // Called at a falling edge: present a request, wait for acceptance, update the model.
  task automatic issue(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] b, input bit hold, output int nwait);
    bit sp, inr;
    int n;
    n = 0;
    vld[d] = 1'b1; wr[d] = w; addr[d] = a; wdat[d] = wd; be[d] = b;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    nwait = n;
    chk("accept_ready", {31'd0, rdy[d]}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) vld[d] = 1'b0;
    sp      = (a == 16'hFFFE);
    inr     = (a < 16'd1024);
    e_err   = !sp && !inr;
    e_known = 1'b1;
    e_rd    = 16'h0000;
    if (w) begin
      if (sp) sp_m[d] = merge(sp_m[d], wd, b);
      else if (inr) begin
        mm[d][a[9:0]] = merge(mm[d][a[9:0]], wd, b);
        if (b == 2'b11) kn[d][a[9:0]] = 1'b1;
      end
    end else if (sp) begin
      e_rd = sp_m[d];
    end else if (inr) begin
      e_rd    = mm[d][a[9:0]];
      e_known = kn[d][a[9:0]];
    end
  endtask

  // Wait for the response of the last accepted request and check it.
  task automatic collect(input int d, input bit hold, input bit scramble);
    int k, low, ws;
    bit got;
    k = 0; low = 0; got = 1'b0;
    ws = (d == 0) ? 0 : 3;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("sp_value", {16'd0, spv[d]}, {16'd0, sp_m[d]});
      if (!rdy[d]) low++;
      if (rv[d]) got = 1'b1;
      else if (scramble) addr[d] = 16'($urandom);
    end
    chk("rsp_valid_seen", {31'd0, got}, 32'd1);
    chk("latency", k, ws + 1);
    chk("ready_low", low, ws + 1);
    chk("rsp_err", {31'd0, rerr[d]}, {31'd0, e_err});
    if (e_known) chk("rsp_rdata", {16'd0, rdat[d]}, {16'd0, e_rd});
    if (!hold) begin
      @(negedge clk);
      chk("rsp_one_pulse", {31'd0, rv[d]}, 32'd0);
      chk("ready_back", {31'd0, rdy[d]}, 32'd1);
    end
  endtask

  task automatic xact(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                      input logic [1:0] b);
    int n;
    issue(d, w, a, wd, b, 1'b0, n);
    collect(d, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0; be[d] = '0;
      sp_m[d] = 16'h03FF;
      for (int i = 0; i < 1024; i++) kn[d][i] = 1'b0;
    end

    // Reset state of both instances.
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, rdy[d]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rv[d]}, 32'd0);
      chk("rst_rdata", {16'd0, rdat[d]}, 32'd0);
      chk("rst_err", {31'd0, rerr[d]}, 32'd0);
      chk("rst_sp", {16'd0, spv[d]}, 32'h03FF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SP read with no wait states.
    xact(0, 1'b0, 16'hFFFE, 16'h0, 2'b00);
    chk("t1_sp_value", {16'd0, spv[0]}, 32'h03FF);

    // Partial write merge.
    xact(0, 1'b1, 16'd5, 16'hBEEF, 2'b11);
    xact(0, 1'b1, 16'd5, 16'h1234, 2'b01);
    xact(0, 1'b0, 16'd5, 16'h0, 2'b00);
    chk("t2_merge", {16'd0, rdat[0]}, 32'd0);
    chk("t2_model", {16'd0, mm[0][5]}, 32'hBE34);
    xact(0, 1'b1, 16'd5, 16'h7777, 2'b00);
    xact(0, 1'b0, 16'd5, 16'h0, 2'b11);

    // Three wait states, back-to-back issue right after the response.
    xact(1, 1'b1, 16'd9, 16'hC0DE, 2'b11);
    xact(1, 1'b0, 16'd9, 16'h0, 2'b00);
    issue(1, 1'b0, 16'd9, 16'h0, 2'b00, 1'b0, nw);
    chk("t3_next_accept", nw, 0);
    collect(1, 1'b0, 1'b0);

    // Out-of-range accesses, including a high address that would alias if truncated.
    xact(0, 1'b1, 16'd0, 16'h5A5A, 2'b11);
    xact(0, 1'b1, 16'd1024, 16'hAAAA, 2'b11);
    xact(0, 1'b0, 16'd1024, 16'h0, 2'b00);
    xact(0, 1'b1, 16'h8000, 16'hAAAA, 2'b11);
    xact(0, 1'b0, 16'd0, 16'h0, 2'b00);
    xact(0, 1'b1, 16'd1023, 16'h3C3C, 2'b11);
    xact(0, 1'b0, 16'd1023, 16'h0, 2'b00);
    xact(0, 1'b0, 16'hFFFF, 16'h0, 2'b00);

    // SP upper-lane write, then asynchronous reset mid-WAIT.
    xact(1, 1'b1, 16'hFFFE, 16'h0200, 2'b10);
    chk("t5_sp_merge", {16'd0, spv[1]}, 32'h02FF);
    xact(1, 1'b1, 16'd7, 16'h1111, 2'b11);
    issue(1, 1'b1, 16'd7, 16'h2222, 2'b11, 1'b0, nw);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", {31'd0, rv[1]}, 32'd0);
    chk("t5_rst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("t5_rst_sp", {16'd0, spv[1]}, 32'h03FF);
    sp_m[0] = 16'h03FF;
    sp_m[1] = 16'h03FF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", {31'd0, rdy[1]}, 32'd1);
    xact(1, 1'b0, 16'd7, 16'h0, 2'b00);
    xact(1, 1'b0, 16'hFFFE, 16'h0, 2'b00);

    // Reset during the response cycle drops rsp_valid at once.
    issue(0, 1'b0, 16'd5, 16'h0, 2'b00, 1'b0, nw);
    @(negedge clk);
    chk("t5_resp_before", {31'd0, rv[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_resp_dropped", {31'd0, rv[0]}, 32'd0);
    chk("t5_resp_rdata", {16'd0, rdat[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // req_valid held high with a changing address while busy.
    issue(1, 1'b0, 16'd9, 16'h0, 2'b00, 1'b1, nw);
    collect(1, 1'b1, 1'b1);
    addr[1] = 16'd7;
    @(negedge clk);
    chk("t6_one_pulse", {31'd0, rv[1]}, 32'd0);
    chk("t6_ready", {31'd0, rdy[1]}, 32'd1);
    issue(1, 1'b0, 16'd7, 16'h0, 2'b00, 1'b0, nw);
    chk("t6_no_extra_wait", nw, 0);
    collect(1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_idle_quiet", {31'd0, rv[1]}, 32'd0);
    end

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        int sel;
        logic [15:0] a;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      a = 16'($urandom_range(0, 15));
        else if (sel == 6) a = 16'hFFFE;
        else if (sel == 7) a = 16'($urandom_range(1020, 1030));
        else if (sel == 8) a = 16'($urandom);
        else               a = 16'd1023;
        xact(d, 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller for the 16-bit CPU's MEM stage. It wraps a synchronous word array with a valid/ready request handshake, a programmable wait-state count, per-byte write enables and a registered read port. The stack-pointer word is a dedicated register mapped at SP_ADDR and initialised on reset. Out-of-range accesses are flagged, never silently aliased.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 16, address width in bits; word-addressed
DEPTH, 1024, number of words in the array; addresses >= DEPTH are out of range
SP_ADDR, 16'hFFFE, word address of the stack-pointer register; always in range, even if >= DEPTH
SP_INIT, 16'h03FF, value loaded into the SP register on reset
WAIT_STATES, 0, extra cycles inserted before each response; range 0..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts the request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables; bit i enables byte lane [8i+7:8i]
rsp_valid  out  1  response valid, held for exactly one cycle
rsp_rdata  out  DATA_W  read data; all zeros for writes and errors
rsp_err  out  1  address is out of range, qualified by rsp_valid
sp_value  out  DATA_W  current SP register contents, continuous

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, SP register=SP_INIT.
- Array contents are not reset.
- Reset mid-operation aborts any pending write. The array write happens only at the accept edge, so a write accepted before reset has already completed.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write, addr, wdata and be.
  - Write: performed at the accept edge.
  - Read: the array is read at the accept edge into a holding register.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - The counter counts from 0 up to WAIT_STATES-1, then the FSM goes to RESP.
- RESP:
  - rsp_valid=1 for one cycle. rsp_rdata and rsp_err are valid in this cycle.
  - req_ready=0. The next state is IDLE.
  - There is no back-to-back acceptance. Throughput is one request per WAIT_STATES+2 cycles.
- Latency from accept edge to the edge that samples rsp_valid=1: WAIT_STATES+1 cycles.
- Byte enables:
  - Lanes with be=0 keep their old value.
  - be=0 overall on a write is legal; it is a no-op write with a normal response.
  - be is ignored on reads; reads always return the full word.
- SP register:
  - Addr==SP_ADDR reads and writes the SP register, with byte enables honoured. The array is not touched.
  - sp_value updates on the clock edge after the write.
- Out of range: addr>=DEPTH and addr!=SP_ADDR.
  - Writes are dropped.
  - Reads return 0.
  - rsp_err=1 in RESP.
- Inputs are ignored while req_ready=0. req_valid held high across a busy window is accepted on the first IDLE cycle.
- Width rules: DEPTH is indexed with clog2(DEPTH) bits. The range compare uses the full ADDR_W-bit address, with no truncation.

Decomposition:
- Package data_mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the default constants DATA_W, ADDR_W, SP_ADDR and SP_INIT, shared with the CPU top level;
  - a helper function for the byte-lane merge (old word, new word, be -> merged word).
- Sub-module mem_array:
  - synchronous single-port RAM with per-lane write enables and a registered read;
  - no reset.
- The controller holds the FSM, wait counter, SP register, range check and response mux.

Test Plan:
1. Reset, then read SP_ADDR with WAIT_STATES=0 -> rsp_valid one cycle after accept; rsp_rdata=16'h03FF, rsp_err=0; sp_value=16'h03FF throughout.
2. Write addr 5, data 16'hBEEF, be=2'b11; then write addr 5, data 16'h1234, be=2'b01; then read addr 5 -> rsp_rdata=16'hBE34.
3. WAIT_STATES=3: read request -> req_ready low for 4 cycles; rsp_valid exactly 4 cycles after the accept edge; the next request is accepted on the following cycle.
4. DEPTH=1024: write addr 1024 with data 16'hAAAA, then read addr 1024 -> rsp_err=1 on both responses, rsp_rdata=0; a read of addr 0 confirms it is unmodified.
5. Write SP_ADDR, data 16'h0200, be=2'b10 -> sp_value=16'h02FF the next cycle. Assert rst_n low asynchronously mid-WAIT -> rsp_valid=0 immediately, sp_value=16'h03FF, req_ready=1 after release.
6. Hold req_valid=1 with changing req_addr during WAIT/RESP -> only the address present in the IDLE acceptance cycle is serviced; exactly one rsp_valid pulse per accepted request.
